// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and helpers for the serial ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND      = 3'd0,
        OP_NOT      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_TRANSFER = 3'd6,
        OP_TEST     = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Only ADD and SUB propagate a carry/borrow between bit slices.
    function automatic logic is_arith(alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu1.sv
// rtl/alu1.sv - one-bit ALU slice; carry_out is carry (ADD) or borrow (SUB)
module alu1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);

    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (alu_op_e'(select))
            OP_AND:      out = a & b;
            OP_NOT:      out = ~a;
            OP_OR:       out = a | b;
            OP_XOR:      out = a ^ b;
            OP_ADD: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (carry_in & (a ^ b));
            end
            OP_SUB: begin
                out       = a ^ b ^ carry_in;
                carry_out = (~a & b) | (carry_in & ~(a ^ b));
            end
            OP_TRANSFER: out = a;
            OP_TEST:     out = a & b;
            default: begin
                out       = 1'b0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial WIDTH-bit ALU driving one alu1 slice LSB first
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             chain;
    logic [CW-1:0]    cnt;
    logic             bit_out;
    logic             bit_carry;

    alu1 u_alu1 (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (chain),
        .select    (op_q),
        .out       (bit_out),
        .carry_out (bit_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_AND;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            chain     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= alu_op_e'(op);
                        chain <= carry_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // One extra RUN cycle after the last shift publishes the collected word.
                    if (cnt == CW'(WIDTH)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        if (op_q != OP_TEST) begin
                            result <= res_sh;
                        end
                        carry_out <= is_arith(op_q) ? chain : 1'b0;
                        zero      <= (res_sh == '0);
                    end else begin
                        res_sh <= {bit_out, res_sh[WIDTH-1:1]};
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        if (is_arith(op_q)) begin
                            chain <= bit_carry;
                        end
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed scoreboard bench for alu_serial_seq (WIDTH=4)
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] model_res = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input string tag);
        exp_t       e;
        logic [W:0] s;
        e.co  = 1'b0;
        e.tag = tag;
        case (o)
            OP_AND:      e.res = x & y;
            OP_NOT:      e.res = ~x;
            OP_OR:       e.res = x | y;
            OP_XOR:      e.res = x ^ y;
            OP_ADD: begin
                s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
                e.res = s[W-1:0];
                e.co  = s[W];
            end
            OP_SUB: begin
                s = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
                e.res = s[W-1:0];
                e.co  = s[W];
            end
            OP_TRANSFER: e.res = x;
            default:     e.res = model_res;
        endcase
        if (o == OP_TEST) begin
            e.z = ((x & y) == '0);
        end else begin
            e.z = (e.res == '0);
            model_res = e.res;
        end
        sb.push_back(e);
    endtask

    task automatic launch(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit expect_done, input string tag);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        carry_in = c;
        start = 1'b1;
        if (expect_done) push_exp(o, x, y, c, tag);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        int   n;
        bit   got;
        exp_t e;
        n = 0;
        got = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_latency"}, got ? n : 0, exp_lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_result"}, {28'd0, result}, {28'd0, e.res});
            chk({e.tag, "_carry"}, {31'd0, carry_out}, {31'd0, e.co});
            chk({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            chk({e.tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic count_dones(input int cycles, input string tag);
        int k;
        k = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done) k++;
        end
        chk({tag, "_extra_done"}, k, 0);
    endtask

    task automatic run_op(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input string tag);
        launch(o, x, y, c, 1'b1, tag);
        wait_done(W + 1, tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {28'd0, result}, 32'd0);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 4'b0111, 4'b1001, 1'b0, "add_wrap");
        run_op(OP_SUB, 4'b0011, 4'b0101, 1'b0, "sub_borrow");
        run_op(OP_SUB, 4'b0101, 4'b0011, 1'b1, "sub_bin");
        run_op(OP_AND, 4'b1100, 4'b1010, 1'b1, "and");
        run_op(OP_OR, 4'b1100, 4'b1010, 1'b1, "or");
        run_op(OP_XOR, 4'b1100, 4'b1010, 1'b0, "xor");
        run_op(OP_NOT, 4'b1100, 4'b1010, 1'b0, "not");
        run_op(OP_TRANSFER, 4'b1100, 4'b1010, 1'b1, "transfer");
        run_op(OP_ADD, 4'b1111, 4'b0000, 1'b1, "add_cin");
        run_op(OP_XOR, 4'b1100, 4'b1010, 1'b0, "xor_pre_test");
        run_op(OP_TEST, 4'b1100, 4'b0011, 1'b0, "test_zero");
        run_op(OP_TEST, 4'b1100, 4'b0110, 1'b0, "test_nonzero");

        // start re-pulsed mid-run is ignored
        launch(OP_ADD, 4'b0011, 4'b0100, 1'b0, 1'b1, "repulse");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        chk("repulse_hold_result", {28'd0, result}, 32'h6);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(W + 1 - 3, "repulse");
        count_dones(10, "repulse");

        // reset in the middle of a run abandons it
        launch(OP_SUB, 4'b1001, 4'b0010, 1'b0, 1'b0, "midrst");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result", {28'd0, result}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        model_res = '0;
        rst_n = 1'b1;
        count_dones(10, "midrst");

        // start held through DONE: back-to-back acceptance on the done cycle
        @(negedge clk);
        op = OP_ADD;
        a = 4'b0101;
        b = 4'b0110;
        carry_in = 1'b0;
        start = 1'b1;
        push_exp(OP_ADD, 4'b0101, 4'b0110, 1'b0, "b2b_first");
        @(posedge clk);
        #1;
        chk("b2b_first_busy", {31'd0, busy}, 32'd1);
        wait_done(W + 1, "b2b_first");
        op = OP_XOR;
        a = 4'b1111;
        b = 4'b0101;
        push_exp(OP_XOR, 4'b1111, 4'b0101, 1'b0, "b2b_second");
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
        chk("b2b_accept_done", {31'd0, done}, 32'd0);
        wait_done(W + 1, "b2b_second");
        count_dones(8, "b2b");
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
